sevenseg_mux_n: RTL and testbench
=================================

Name: sevenseg_mux_n

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Successor to the fixed 4-digit multiplexer. Adds:
  - configurable digit count and dwell time
  - per-digit decimal point and blanking
  - tear-free frame capture
  - 16-level PWM brightness
  - registered, glitch-free outputs
- Sits between datapath/debug registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits multiplexed (2..8).
- DWELL_CYCLES, 16384, clk cycles each digit stays selected. Must be a multiple of 16 and ≥ 16.
- CNT_W, 16, width of dwell counter. Must satisfy 2^CNT_W ≥ DWELL_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- in  in  4*NUM_DIGITS  hex nibbles. Nibble [4k+3:4k] is digit k; digit NUM_DIGITS-1 is leftmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit).
- blank_in  in  NUM_DIGITS  per-digit blank (1 = digit dark).
- brightness  in  4  PWM level; 0 = dimmest visible, 15 = full.
- anode  out  NUM_DIGITS  digit enables, active-low, one-cold.
- sevenSeg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

Behaviour:
- Reset values:
  - anode = all ones; sevenSeg = 8'hFF; frame_done = 0.
  - dwell counter = 0; digit index = NUM_DIGITS-1 (leftmost first).
  - shadow registers = 0.
- Dwell counter:
  - Increments every cycle.
  - At DWELL_CYCLES-1 it wraps to 0 and the digit index decrements.
  - Digit index 0 wraps to NUM_DIGITS-1.
- Frame capture:
  - in/dp_in/blank_in/brightness are sampled into shadow registers only on the cycle where the digit index wraps to NUM_DIGITS-1 with the counter at 0, and on the first cycle after reset release.
  - Mid-frame input changes are never visible until the next frame.
- frame_done:
  - Asserted for exactly one cycle, coincident with the capture cycle (the cycle the counter wraps while the digit index is 0).
- Outputs are registered: anode/sevenSeg reflect the counter/index state of the previous cycle (1-cycle latency).
- PWM:
  - slot = counter / (DWELL_CYCLES/16).
  - Digit is lit while slot ≤ shadow brightness. Otherwise anode = all ones and sevenSeg = 8'hFF.
- Blanking: if the shadow blank bit of the current digit is set, anode = all ones and sevenSeg = 8'hFF for the entire dwell.
- Ghosting guard: on counter == 0 of every dwell, anode = all ones for that single cycle, so no two digits are ever enabled in one cycle.
- Decode: hex 0..F to standard segment patterns, e.g. 0 -> 8'hC0, 8 -> 8'h80, F -> 8'h8E. dp bit = ~dp_shadow[k].
- Invariant: at most one anode bit is low in any cycle.
- rst asserted mid-dwell: all state returns to reset values on the next edge; no partial-digit output continues.

Optional Feature:
- Macro SEVSEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading-zero blanking applies to digits from the left whose shadow nibble is 0. They are blanked as if blank_in were set.
  - Blanking stops at the first nonzero digit.
  - Digit 0 is never auto-blanked.
  - A lit dp stops suppression at that digit and shows "0.".
- Undefined: zeros are always displayed; only blank_in blanks.

Decomposition:
- Package sevenseg_pkg holds:
  - segment encoding constants (SEG_BLANK = 8'hFF, 16-entry hex pattern constant)
  - the anode-off constant helper
  - the brightness-slot count of 16
- One sub-module: sevenseg_hex_decode, a combinational 4-bit -> 7-segment active-low decoder instantiated once.

Test Plan:
- NUM_DIGITS=4, DWELL_CYCLES=16, in=16'h12AF, brightness=15 -> anode steps 0111, 1011, 1101, 1110 each 16 cycles. sevenSeg = 8'hF9, 8'hA4, 8'h88, 8'h8E. frame_done pulses every 64 cycles.
- Change in from 16'h1234 to 16'h5678 mid-frame (digit 2 active) -> remaining digits of the current frame still show 3,4; new values appear only from the next frame's first digit.
- brightness=3, DWELL_CYCLES=16 -> each digit lit for counter 0..3 only, with cycle 0 dark (ghost guard), so 3 lit cycles per dwell; dark for cycles 4..15.
- blank_in=4'b0100, dp_in=4'b0001 -> digit 2 anode never low; digit 0 sevenSeg bit7 = 0.
- SEVSEG_LEADING_ZERO_BLANK_EN, in=16'h0050 -> digits 3,2 dark; digits 1,0 show 5,0. With in=16'h0000, only digit 0 shows "0".
- Assert rst for 1 cycle mid-dwell of digit 1 -> next cycle anode=4'hF, sevenSeg=8'hFF; scanning restarts at the leftmost digit with counter 0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment patterns,
// the anode-off helper and the number of PWM brightness slots per dwell.
package sevenseg_pkg;

    localparam int unsigned BRIGHT_SLOTS = 16;
    localparam int unsigned MAX_DIGITS   = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, dp off; entry 15 is leftmost.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [MAX_DIGITS-1:0] anode_off();
        return '1;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment {g,f,e,d,c,b,a} decoder.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [7:0] pattern;

    always_comb begin
        pattern = HEX_SEG[hex];
        seg     = pattern[6:0];
    end

endmodule

// File: rtl/sevenseg_mux_n.sv
// N-digit time-multiplexed common-anode seven-segment driver with per-frame
// input capture, PWM brightness, blanking and registered outputs.
// Optional macro SEVSEG_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module sevenseg_mux_n
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 16384,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              sevenSeg,
    output logic                    frame_done
);

    localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
    localparam int unsigned SLOT_LEN = DWELL_CYCLES / BRIGHT_SLOTS;

    localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF_ALL = anode_off();
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF     = ANODE_OFF_ALL[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_in;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [3:0]              sh_bright;

    logic                    dwell_end;
    logic                    frame_end;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lz;
    logic [CNT_W+4:0]        lit_lim;
    logic                    lit;
    logic [6:0]              seg7;
    logic [NUM_DIGITS-1:0]   anode_nxt;

    assign dwell_end = (cnt == CNT_LAST);
    assign frame_end = dwell_end && (idx == '0);
    // Capturing on the first cycle of every frame also covers the first cycle out of reset.
    assign capture   = (cnt == '0) && (idx == IDX_LAST);

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic suppress;

    always_comb begin
        lz_mask  = '0;
        suppress = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (sh_in[4*k +: 4] != 4'h0 || sh_dp[k])
                suppress = 1'b0;
            lz_mask[k] = suppress;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = sh_in[4*k +: 4];
                cur_dp    = sh_dp[k];
                cur_blank = sh_blank[k];
                cur_lz    = lz_mask[k];
            end
        end
    end

    sevenseg_hex_decode u_dec (
        .hex (cur_nib),
        .seg (seg7)
    );

    // slot <= brightness  <=>  cnt < (brightness+1)*SLOT_LEN
    assign lit_lim = (CNT_W+5)'(SLOT_LEN) * (CNT_W+5)'({1'b0, sh_bright} + 5'd1);
    assign lit     = (cnt != '0) && ({5'b0, cnt} < lit_lim) && !cur_blank && !cur_lz;

    always_comb begin
        anode_nxt = ANODE_OFF;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (lit && idx == IDX_W'(k))
                anode_nxt[k] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= IDX_LAST;
            sh_in      <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_bright  <= '0;
            anode      <= ANODE_OFF;
            sevenSeg   <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            cnt <= dwell_end ? '0 : cnt + 1'b1;
            if (dwell_end)
                idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
            if (capture) begin
                sh_in     <= in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_bright <= brightness;
            end
            frame_done <= frame_end;
            anode      <= anode_nxt;
            sevenSeg   <= lit ? {~cur_dp, seg7} : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Self-checking bench for sevenseg_mux_n (4 digits, 16-cycle dwell) against a
// cycle-indexed behavioural model plus hand-computed literal pins.
module tb_sevenseg_mux_n;

    localparam int HIST = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  brightness = 4'h0;
    logic [3:0]  anode;
    logic [7:0]  sevenSeg;
    logic        frame_done;

    int vec = 0;
    int err = 0;
    int cyc = 0;
    bit valid = 1'b0;

    logic [15:0] h_in [HIST];
    logic [3:0]  h_dp [HIST];
    logic [3:0]  h_bl [HIST];
    logic [3:0]  h_br [HIST];

    logic [7:0] hexp [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    sevenseg_mux_n #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (16),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .brightness (brightness),
        .anode      (anode),
        .sevenSeg   (sevenSeg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            cyc   = 0;
            valid = 1'b1;
        end else if (valid && cyc < HIST - 1) begin
            cyc = cyc + 1;
        end
    end

    // Model: output in cycle c shows the digit selected in cycle c-1, with frame f's
    // content taken from the inputs present in cycle 64*f.
    always @(negedge clk) begin
        if (valid && !rst) begin
            int p, cn, dig, fb;
            logic [15:0] s_in;
            logic [3:0]  s_dp, s_bl, s_br, nib, exp_an;
            logic [7:0]  exp_seg;
            logic        lit, lz, exp_fd;
            h_in[cyc] = in;
            h_dp[cyc] = dp_in;
            h_bl[cyc] = blank_in;
            h_br[cyc] = brightness;
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
            exp_fd  = 1'b0;
            if (cyc >= 1) begin
                p    = cyc - 1;
                cn   = p % 16;
                dig  = 3 - ((p / 16) % 4);
                fb   = 64 * (p / 64);
                s_in = h_in[fb];
                s_dp = h_dp[fb];
                s_bl = h_bl[fb];
                s_br = h_br[fb];
                nib  = s_in[4*dig +: 4];
                lz   = 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
                if (dig != 0) begin
                    lz = 1'b1;
                    for (int k = 3; k >= dig; k--)
                        if (s_in[4*k +: 4] != 4'h0 || s_dp[k]) lz = 1'b0;
                end
`endif
                lit = (cn != 0) && (cn <= int'(s_br)) && !s_bl[dig] && !lz;
                if (lit) begin
                    exp_an  = ~(4'b0001 << dig);
                    exp_seg = {~s_dp[dig], hexp[nib][6:0]};
                end
                exp_fd = (cyc % 64 == 0);
            end
            chk("anode", {28'h0, anode}, {28'h0, exp_an});
            chk("sevenSeg", {24'h0, sevenSeg}, {24'h0, exp_seg});
            chk("frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
            chk("onecold", $countones(~anode) <= 1, 1);
        end
    end

    task automatic goto(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != c && n < 3000);
        if (cyc != c) chk("goto_timeout", cyc, c);
    endtask

    task automatic pin(input int c, input string nm, input logic [3:0] an, input logic [7:0] sg);
        goto(c);
        chk({nm, "_anode"}, {28'h0, anode}, {28'h0, an});
        chk({nm, "_seg"}, {24'h0, sevenSeg}, {24'h0, sg});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Basic scan, full brightness
        in = 16'h12AF; dp_in = 4'h0; blank_in = 4'h0; brightness = 4'hF;
        do_reset();
        pin(0,  "rst_state", 4'hF, 8'hFF);
        chk("rst_fd", {31'h0, frame_done}, 32'h0);
        pin(1,  "ghost",     4'hF, 8'hFF);
        pin(2,  "dig3",      4'h7, 8'hF9);
        pin(17, "ghost2",    4'hF, 8'hFF);
        pin(18, "dig2",      4'hB, 8'hA4);
        pin(34, "dig1",      4'hD, 8'h88);
        pin(50, "dig0",      4'hE, 8'h8E);
        goto(63);
        chk("fd_63", {31'h0, frame_done}, 32'h0);
        goto(64);
        chk("fd_64", {31'h0, frame_done}, 32'h1);

        // Reduced brightness
        brightness = 4'h3;
        do_reset();
        pin(4, "br3_lit",  4'h7, 8'hF9);
        pin(5, "br3_dark", 4'hF, 8'hFF);

        // Mid-frame input change is deferred to the next frame
        in = 16'h1234; brightness = 4'hF;
        do_reset();
        goto(20);
        in = 16'h5678;
        pin(34, "defer_d1", 4'hD, 8'hB0);
        pin(50, "defer_d0", 4'hE, 8'h99);
        pin(66, "newframe", 4'h7, 8'h92);

        // Blanking and decimal point
        in = 16'h1234; blank_in = 4'b0100; dp_in = 4'b0001;
        do_reset();
        pin(18, "blank_d2", 4'hF, 8'hFF);
        pin(50, "dp_d0",    4'hE, 8'h19);

        // Reset asserted mid-dwell of digit 1
        in = 16'h12AF; blank_in = 4'h0; dp_in = 4'h0;
        do_reset();
        goto(40);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pin(0, "midrst",  4'hF, 8'hFF);
        pin(2, "restart", 4'h7, 8'hF9);

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        in = 16'h0050;
        do_reset();
        pin(2,  "lz_d3", 4'hF, 8'hFF);
        pin(18, "lz_d2", 4'hF, 8'hFF);
        pin(34, "lz_d1", 4'hD, 8'h92);
        pin(50, "lz_d0", 4'hE, 8'hC0);
        in = 16'h0000;
        do_reset();
        pin(34, "lz0_d1", 4'hF, 8'hFF);
        pin(50, "lz0_d0", 4'hE, 8'hC0);
`else
        in = 16'h0050;
        do_reset();
        pin(2,  "zero_d3", 4'h7, 8'hC0);
        pin(18, "zero_d2", 4'hB, 8'hC0);
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        err++;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $fatal(1, "watchdog");
    end

endmodule
